// File: rtl/es_perifericos.sv
// es_perifericos: memory-mapped I/O block with two output ports, two synchronised input ports, a TX FIFO and an interval timer.
// Build option: define ES_TIMER_EN to include the interval timer; otherwise its registers read 0 and irq stays low.
module es_perifericos #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PRESC      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] direcciones,
    inout  wire  [15:0] datos,
    input  logic        oe,
    input  logic        rd,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (PRESC < 1 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("es_perifericos: PRESC must be >=1 and FIFO_DEPTH a power of two in 2..16");
    end

    logic        sel;
    logic [3:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        pend_w;

    assign sel    = (direcciones[15:4] == BASE_ADDR[15:4]);
    assign offset = direcciones[3:0];
    // rd and oe together is a bus conflict: neither path is enabled.
    assign wr_en  = sel & oe & ~rd;
    assign rd_en  = sel & rd & ~oe;
    assign wdata  = datos;
    assign datos  = rd_en ? rdata : 16'hzzzz;

    // Two-flop synchronisers, one chain per input port.
    logic [15:0] pin_raw  [2];
    logic [15:0] pin_sync [2];
    assign pin_raw[0] = in_a;
    assign pin_raw[1] = in_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        logic [15:0] meta_reg;
        logic [15:0] sync_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                meta_reg <= '0;
                sync_reg <= '0;
            end else begin
                meta_reg <= pin_raw[gi];
                sync_reg <= meta_reg;
            end
        end
        assign pin_sync[gi] = sync_reg;
    end

    logic [15:0] out_a_reg, out_b_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_a_reg <= '0;
            out_b_reg <= '0;
        end else begin
            if (wr_en && offset == 4'd0) out_a_reg <= wdata;
            if (wr_en && offset == 4'd1) out_b_reg <= wdata;
        end
    end
    assign out_a = out_a_reg;
    assign out_b = out_b_reg;

    // TX FIFO: RAM array plus a registered head word for first-word-fall-through.
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, head_idx;
    logic [CW-1:0] count_reg, count_next;
    logic [15:0]   head_reg, head_next;
    logic          ovf_reg;
    logic          fifo_full, fifo_empty, push_req, push_acc, push_drop, pop;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = head_reg;
    assign pop        = tx_valid & tx_ready;
    assign push_req   = wr_en & (offset == 4'd8);
    assign push_acc   = push_req & (~fifo_full | pop);
    assign push_drop  = push_req & fifo_full & ~pop;
    assign count_next = count_reg + CW'(push_acc) - CW'(pop);
    assign head_idx   = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            // The new head is the word being written only when the FIFO drains down to it this cycle.
            if (push_acc && head_idx == wr_ptr_reg) head_next = wdata;
            else                                    head_next = fifo_mem[head_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) fifo_mem[wr_ptr_reg] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)      rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            head_reg  <= head_next;
            if (push_drop)                                  ovf_reg <= 1'b1;
            else if (wr_en && offset == 4'd7 && wdata[3])   ovf_reg <= 1'b0;
        end
    end

`ifdef ES_TIMER_EN
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [2:0]    tctrl_reg;
    logic [15:0]   tcmp_reg, tcnt_reg;
    logic [PW-1:0] presc_reg;
    logic          pend_reg, tick, hit;

    assign tick = tctrl_reg[0] & (presc_reg == PRESC_LAST);
    assign hit  = tick & (tcnt_reg == tcmp_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            tctrl_reg <= '0;
            tcmp_reg  <= '0;
            tcnt_reg  <= '0;
            presc_reg <= '0;
            pend_reg  <= 1'b0;
        end else begin
            presc_reg <= (tctrl_reg[0] && !tick) ? presc_reg + PW'(1) : '0;
            if (tick) begin
                if (hit) begin
                    if (tctrl_reg[1]) tcnt_reg     <= '0;
                    else              tctrl_reg[0] <= 1'b0;
                end else begin
                    tcnt_reg <= tcnt_reg + 16'd1;
                end
            end
            // CPU writes land after the timer update so they take precedence.
            if (wr_en && offset == 4'd4) tctrl_reg <= wdata[2:0];
            if (wr_en && offset == 4'd5) tcmp_reg  <= wdata;
            if (wr_en && offset == 4'd6) tcnt_reg  <= '0;
            if (hit)                                      pend_reg <= 1'b1;
            else if (wr_en && offset == 4'd7 && wdata[0]) pend_reg <= 1'b0;
        end
    end
    assign pend_w = pend_reg;
    assign irq    = pend_reg & tctrl_reg[2];
`else
    assign pend_w = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (offset)
            4'd0: rdata = out_a_reg;
            4'd1: rdata = out_b_reg;
            4'd2: rdata = pin_sync[0];
            4'd3: rdata = pin_sync[1];
`ifdef ES_TIMER_EN
            4'd4: rdata = {13'd0, tctrl_reg};
            4'd5: rdata = tcmp_reg;
            4'd6: rdata = tcnt_reg;
`endif
            4'd7: rdata = {7'd0, 5'(count_reg), ovf_reg, fifo_empty, fifo_full, pend_w};
            default: rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_es_perifericos.sv
// Bench for es_perifericos: randomized bus traffic against a queue-based reference model, scoreboard-checked by a negedge monitor.
module tb_es_perifericos;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] direcciones;
    wire  [15:0] datos;
    logic        oe, rd;
    logic [15:0] in_a, in_b;
    logic [15:0] out_a, out_b, tx_data;
    logic        tx_valid, tx_ready, irq;
    logic [15:0] drv_data;
    logic        drv_en;

    always #5 clk = ~clk;
    assign datos = drv_en ? drv_data : 16'hzzzz;

    es_perifericos #(.BASE_ADDR(16'hFF00), .FIFO_DEPTH(DEPTH), .PRESC(4)) dut (
        .clk(clk), .reset(reset), .direcciones(direcciones), .datos(datos),
        .oe(oe), .rd(rd), .in_a(in_a), .in_b(in_b), .out_a(out_a), .out_b(out_b),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_out_a, m_out_b, m_in_a, m_in_b, m_tctrl, m_tcmp, m_tcnt;
    logic        m_ovf, m_pend;
    logic [15:0] fifo_q[$];
    logic [15:0] rd_q[$];
    string       rd_name_q[$];
    logic        rd_chk = 1'b0;
    logic        mon_en = 1'b0;

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_read(logic [3:0] off);
        case (off)
            4'd0: return m_out_a;
            4'd1: return m_out_b;
            4'd2: return m_in_a;
            4'd3: return m_in_b;
`ifdef ES_TIMER_EN
            4'd4: return m_tctrl;
            4'd5: return m_tcmp;
            4'd6: return m_tcnt;
`endif
            4'd7: return {7'd0, 5'(fifo_q.size()), m_ovf, fifo_q.size() == 0,
                          fifo_q.size() == DEPTH, m_pend};
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor: checks reads and FIFO drains whenever the DUT presents them.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_chk) begin
                if (rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rd_scoreboard: got %h expected nothing queued", datos);
                end else begin
                    chk(rd_name_q.pop_front(), datos, rd_q.pop_front());
                end
            end
            chk("tx_valid", {15'd0, tx_valid}, {15'd0, fifo_q.size() != 0});
            if (tx_valid && tx_ready) begin
                if (fifo_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_scoreboard: got %h expected no word", tx_data);
                end else begin
                    chk("tx_data", tx_data, fifo_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk);
        m_out_a = '0; m_out_b = '0; m_in_a = '0; m_in_b = '0;
        m_tctrl = '0; m_tcmp = '0; m_tcnt = '0; m_ovf = 1'b0; m_pend = 1'b0;
        fifo_q.delete();
        #1;
        reset = 1'b0; oe = 1'b0; rd = 1'b0; drv_en = 1'b0;
        repeat (2) @(posedge clk);
        m_in_a = in_a;
        m_in_b = in_b;
        #1;
    endtask

    task automatic do_write(logic [15:0] addr, logic [15:0] d);
        logic sel;
        logic pop_now;
        int   size_now;
        sel      = (addr[15:4] == 12'hFF0);
        size_now = fifo_q.size();
        pop_now  = tx_ready && size_now > 0;
        direcciones = addr; drv_data = d; drv_en = 1'b1; oe = 1'b1; rd = 1'b0;
        @(posedge clk);
        if (sel) begin
            case (addr[3:0])
                4'd0: m_out_a = d;
                4'd1: m_out_b = d;
`ifdef ES_TIMER_EN
                4'd4: m_tctrl = {13'd0, d[2:0]};
                4'd5: m_tcmp  = d;
                4'd6: m_tcnt  = '0;
`endif
                4'd7: begin
                    if (d[3]) m_ovf  = 1'b0;
                    if (d[0]) m_pend = 1'b0;
                end
                4'd8: begin
                    if (size_now == DEPTH && !pop_now) m_ovf = 1'b1;
                    else                               fifo_q.push_back(d);
                end
                default: ;
            endcase
        end
        #1;
        oe = 1'b0; drv_en = 1'b0;
    endtask

    task automatic do_read(logic [15:0] addr, string name);
        rd_q.push_back((addr[15:4] == 12'hFF0) ? exp_read(addr[3:0]) : 16'hzzzz);
        rd_name_q.push_back(name);
        direcciones = addr; drv_en = 1'b0; oe = 1'b0; rd = 1'b1; rd_chk = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic do_conflict(logic [15:0] addr);
        rd_q.push_back(16'hzzzz);
        rd_name_q.push_back("conflict_z");
        direcciones = addr; drv_en = 1'b0; oe = 1'b1; rd = 1'b1; rd_chk = 1'b1;
        @(posedge clk);
        #1;
        oe = 1'b0; rd = 1'b0; rd_chk = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        tx_ready = 1'b1;
        while (fifo_q.size() != 0 && c < 40) begin
            @(posedge clk); #1; c++;
        end
        tx_ready = 1'b0;
        chk("drain_timeout", 16'(fifo_q.size()), 16'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          c;
        logic [15:0] v;
        logic        irq_seen;
        reset = 1'b1; direcciones = '0; oe = 1'b0; rd = 1'b0; drv_en = 1'b0;
        drv_data = '0; in_a = '0; in_b = '0; tx_ready = 1'b0;
        do_reset();
        mon_en = 1'b1;

        // Reset state and output port write/read
        do_read(16'hFF07, "status_reset");
        chk("out_a_reset", out_a, 16'h0000);
        do_write(16'hFF00, 16'hA5A5);
        do_read(16'hFF00, "read_out_a");
        chk("out_a_port", out_a, 16'hA5A5);
        // Reset with a concurrent write: reset wins
        direcciones = 16'hFF00; drv_data = 16'hFFFF; drv_en = 1'b1; oe = 1'b1;
        do_reset();
        chk("out_a_after_reset", out_a, 16'h0000);
        do_read(16'hFF00, "read_out_a_reset");

        // Input synchroniser latency
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            in_b = v;
            in_a = ~v;
            do_read(16'hFF03, "in_b_edge0");
            do_read(16'hFF03, "in_b_edge1");
            m_in_b = v;
            m_in_a = ~v;
            do_read(16'hFF03, "in_b_edge2");
            do_read(16'hFF02, "in_a_settled");
        end

        // FIFO overflow then ordered drain
        do_reset();
        for (int i = 1; i <= 9; i++) do_write(16'hFF08, 16'(i));
        do_read(16'hFF07, "status_full_ovf");
        chk("tx_head_full", tx_data, 16'h0001);
        drain();
        do_read(16'hFF07, "status_drained");
        chk("tx_data_empty", tx_data, 16'h0000);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 1; i <= 8; i++) do_write(16'hFF08, 16'(16'h10 + i));
        tx_ready = 1'b1;
        do_write(16'hFF08, 16'hBEEF);
        tx_ready = 1'b0;
        do_read(16'hFF07, "status_full_pushpop");
        drain();

        // Randomized traffic
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        do_reset();
        for (int i = 0; i < 80; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin
                    do_write(16'hFF00 | 16'($urandom_range(0, 1)), 16'($urandom));
                    chk("rand_out_a", out_a, m_out_a);
                    chk("rand_out_b", out_b, m_out_b);
                end
                1, 2: do_read(16'hFF00 | 16'($urandom_range(0, 15)), "rand_read");
                3: do_write(16'hFF08, 16'($urandom));
                4: do_write(16'hFF07, 16'($urandom));
                5: do_write(16'hFF00 | 16'($urandom_range(9, 15)), 16'($urandom));
                6: do_conflict(16'hFF00 | 16'($urandom_range(0, 1)));
                default: begin
                    do_write(16'hFE00 | 16'($urandom_range(0, 1)), 16'($urandom));
                    do_read(16'hFE00 | 16'($urandom_range(0, 15)), "unselected_z");
                end
            endcase
        end
        tx_ready = 1'b0;
        do_read(16'hFF00, "rand_final_out_a");
        do_read(16'hFF01, "rand_final_out_b");
        do_read(16'hFF07, "rand_final_status");
        drain();

`ifdef ES_TIMER_EN
        // Timer with autoreload: first irq 12 clk after enable, then every 12 clk
        do_reset();
        do_write(16'hFF05, 16'd2);
        do_write(16'hFF04, 16'd7);
        c = 0;
        while (!irq && c < 40) begin @(posedge clk); #1; c++; end
        chk("irq_first_delay", 16'(c), 16'd12);
        do_write(16'hFF07, 16'h0001);
        chk("irq_after_w1c", {15'd0, irq}, 16'd0);
        c = 1;
        while (!irq && c < 40) begin @(posedge clk); #1; c++; end
        chk("irq_period", 16'(c), 16'd12);
        do_read(16'hFF04, "tctrl_readback");
        // One-shot: fires once and clears enable, count holds
        do_write(16'hFF04, 16'd0);
        do_write(16'hFF07, 16'h0001);
        do_write(16'hFF06, 16'hFFFF);
        do_read(16'hFF06, "tcnt_cleared");
        do_write(16'hFF05, 16'd1);
        do_write(16'hFF04, 16'd5);
        c = 0;
        while (!irq && c < 40) begin @(posedge clk); #1; c++; end
        chk("irq_oneshot_delay", 16'(c), 16'd8);
        m_tctrl = 16'd4;
        m_tcnt  = 16'd1;
        m_pend  = 1'b1;
        idle(10);
        do_read(16'hFF04, "tctrl_en_cleared");
        do_read(16'hFF06, "tcnt_held");
        do_read(16'hFF07, "status_pend");
`else
        // Timer absent: registers read 0, irq never asserts
        do_reset();
        do_write(16'hFF04, 16'd7);
        do_read(16'hFF04, "tctrl_absent");
        do_write(16'hFF05, 16'd2);
        do_read(16'hFF05, "tcmp_absent");
        irq_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            irq_seen = irq_seen | irq;
        end
        chk("irq_idle", {15'd0, irq_seen}, 16'd0);
        do_read(16'hFF07, "status_no_pend");
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
